data_mem_ctrl: RTL
==================

# data_mem_ctrl

Parametrised, self-initialising data memory for the CSE141L datapath, the successor to the single-port 8x256 data memory. Provides one synchronous write port and two independent read ports (A for the load path, B for debug/scoreboard). Preload constants are written by a sequential init sweep after reset instead of a single-cycle reset loop. Re-initialisation can be requested at run time. A Ready flag gates the rest of the core.

## Interface
- DW, 8, data width in bits
- AW, 8, address width; depth = 2**AW words
- REG_READ, 0, 0 = combinational read ports; 1 = registered read ports (one cycle latency)

- Clk  input  1  clock; all state changes on rising edge
- Reset  input  1  asynchronous, active-low reset
- WriteEn  input  1  write request; honoured only when Ready=1 and InitReq=0
- WrAddr  input  AW  write address
- DataIn  input  DW  write data
- RdAddrA  input  AW  read address, port A
- DataOutA  output  DW  read data, port A
- RdAddrB  input  AW  read address, port B
- DataOutB  output  DW  read data, port B
- InitReq  input  1  single-cycle request to re-run the init sweep
- Ready  output  1  1 = memory initialised and accepting writes
- WrDropped  output  1  registered one-cycle pulse: a WriteEn was refused on the previous edge

## Operation
- States: INIT, RUN. Reset asserted forces INIT, pointer=0, Ready=0, WrDropped=0. The memory array itself is not reset.
- INIT: each edge writes preload(ptr) to Core[ptr], then ptr+1. The edge that writes ptr=2**AW-1 sets Ready=1 and moves to RUN.
- preload(a), values truncated to DW bits, 0 everywhere else:
  - 0→1, 1→1, 2→3
  - 7→33, 8→207, 9→63, 10→186
  - 16→254, 244→5
  - Entries with address ≥ 2**AW are ignored.
- RUN: WriteEn=1 writes DataIn to Core[WrAddr] on the edge. InitReq=1 moves to INIT with ptr=0 and clears Ready on that edge.
- Simultaneous InitReq and WriteEn in RUN: InitReq wins, write not performed, WrDropped=1 next cycle.
- WriteEn while in INIT is not performed; WrDropped=1 next cycle.
- InitReq while in INIT restarts the sweep at ptr=0.
- Reads while Ready=0 return 0 on both ports, regardless of array contents.
- Reads in RUN:
  - REG_READ=0: DataOutX = Core[RdAddrX] combinationally.
  - REG_READ=1: DataOutX is registered from Core[RdAddrX] at the edge; reset value 0.
- Read-during-write to the same address is read-first:
  - REG_READ=0 shows old data until the edge.
  - REG_READ=1 captures old data on the write edge.
- Ports A and B may address the same word with no restriction.

## Timing
- Reset values: Ready=0, WrDropped=0, DataOutA=DataOutB=0.
- Init latency: Ready rises on the 2**AW-th rising edge after Reset deasserts (256 edges at default). The first write is accepted on the following edge.
- Write latency: data is visible on a combinational read port immediately after the write edge, or one edge later on a registered port.
- Reset asserted mid-init or mid-run: Ready=0 and outputs=0 immediately (asynchronous); the sweep restarts from 0 after release.
- The pointer is AW+1 bits or uses a terminal compare, so there is no wrap-around into a second sweep.

## Test plan
- Reset release, idle 256 cycles, default params → Ready rises on edge 256; DataOutA at addresses 0,2,8,16,244 reads 1,3,207,254,5; address 3 reads 0.
- After Ready, write 0xAA to address 5, read port A and port B at 5 simultaneously → both 0xAA. With REG_READ=1, both show 0xAA one cycle later.
- WriteEn to address 5 at edge 100 of init → write not performed, WrDropped pulses one cycle, address 5 reads 0 after Ready.
- In RUN, pulse InitReq together with WriteEn (addr 0, data 9) → WrDropped=1, Ready=0 for 256 edges, then address 0 reads 1.
- Assert Reset at init edge 50, release → Ready stays 0 until 256 edges after release.
- DW=4, AW=4 → Ready after 16 edges; address 8 reads 207&0xF=0xF; addresses 16 and 244 are ignored.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: self-initialising data memory with one write port and two
// independent read ports. After reset (or on InitReq) a sequential sweep
// writes the preload constants into every word. Ready then rises and the
// memory accepts writes.
//
// Ports:
//   Clk       clock, rising edge
//   Reset     asynchronous active-low reset
//   WriteEn   write request, honoured only in RUN without InitReq
//   WrAddr    write address
//   DataIn    write data
//   RdAddrA   port A read address (load path)
//   DataOutA  port A read data
//   RdAddrB   port B read address (debug/scoreboard)
//   DataOutB  port B read data
//   InitReq   single-cycle request to re-run the init sweep
//   Ready     memory initialised and accepting writes
//   WrDropped one-cycle pulse, a WriteEn was refused on the previous edge
module data_mem_ctrl #(
    parameter int unsigned DW       = 8,
    parameter int unsigned AW       = 8,
    parameter bit          REG_READ = 1'b0
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          WriteEn,
    input  logic [AW-1:0] WrAddr,
    input  logic [DW-1:0] DataIn,
    input  logic [AW-1:0] RdAddrA,
    output logic [DW-1:0] DataOutA,
    input  logic [AW-1:0] RdAddrB,
    output logic [DW-1:0] DataOutB,
    input  logic          InitReq,
    output logic          Ready,
    output logic          WrDropped
);

    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          ready_q;
    logic          dropped_q, dropped_d;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] core_q [DEPTH];

    // Preload constant for a word; addresses beyond the depth never reach here.
    function automatic logic [DW-1:0] preload(input logic [AW-1:0] a);
        logic [31:0]   ai;
        logic [DW-1:0] v;
        ai = 32'(a);
        case (ai)
            32'd0, 32'd1: v = DW'(1);
            32'd2:        v = DW'(3);
            32'd7:        v = DW'(33);
            32'd8:        v = DW'(207);
            32'd9:        v = DW'(63);
            32'd10:       v = DW'(186);
            32'd16:       v = DW'(254);
            32'd244:      v = DW'(5);
            default:      v = '0;
        endcase
        return v;
    endfunction

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_INIT;
            ptr_q     <= '0;
            ready_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ready_q   <= (state_d == ST_RUN);
            dropped_q <= dropped_d;
        end
    end

    // Next-state, sweep pointer and memory write port selection
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        dropped_d = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = WrAddr;
        mem_wdata = DataIn;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_addr  = ptr_q;
                mem_wdata = preload(ptr_q);
                dropped_d = WriteEn;
                if (InitReq) begin
                    ptr_d = '0;
                end else if (ptr_q == AW'(DEPTH - 1)) begin
                    // Terminal compare: no wrap into a second sweep
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            ST_RUN: begin
                if (InitReq) begin
                    state_d   = ST_INIT;
                    ptr_d     = '0;
                    dropped_d = WriteEn;
                end else begin
                    mem_we = WriteEn;
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    // Storage array, intentionally not reset
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            core_q[mem_addr] <= mem_wdata;
        end
    end

    // Read ports: zero while not ready; registered variant captures read-first data
    if (REG_READ) begin : g_reg_read
        logic [DW-1:0] rd_a_q, rd_b_q;
        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                rd_a_q <= '0;
                rd_b_q <= '0;
            end else begin
                rd_a_q <= (state_d == ST_RUN) ? core_q[RdAddrA] : '0;
                rd_b_q <= (state_d == ST_RUN) ? core_q[RdAddrB] : '0;
            end
        end
        assign DataOutA = rd_a_q;
        assign DataOutB = rd_b_q;
    end else begin : g_comb_read
        assign DataOutA = ready_q ? core_q[RdAddrA] : '0;
        assign DataOutB = ready_q ? core_q[RdAddrB] : '0;
    end

    assign Ready     = ready_q;
    assign WrDropped = dropped_q;

endmodule
